// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : Shares single-port VRAM between display reads and a buffered
//            pixel writer; writes drain only while the display is blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int DW    = 15,
  parameter int CW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                       pclk,
  input  logic                       rstn,
  input  logic                       disp_en,
  input  logic [DW-1:0]              disp_addr,
  output logic [CW-1:0]              disp_rdata,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DW-1:0]              wr_addr,
  input  logic [CW-1:0]              wr_data,
  output logic [DW-1:0]              mem_addr,
  output logic                       mem_we,
  output logic [CW-1:0]              mem_wdata,
  input  logic [CW-1:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;
  localparam int c_ew = DW + CW;
  localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_lw-1:0] r_level;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [c_ew-1:0] w_head;

  assign w_full  = (r_level == c_full);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rptr];

  // Readiness comes only from the registered level, so a full FIFO refuses
  // a write even in a cycle where it is also draining.
  assign wr_ready = rstn & ~w_full;
  assign w_push   = wr_valid & wr_ready;

  // Display always wins; the writer only gets the port while blanking.
  assign w_pop    = rstn & ~disp_en & ~w_empty;

  assign mem_we     = w_pop;
  assign mem_addr   = w_pop ? w_head[c_ew-1:CW] : disp_addr;
  assign mem_wdata  = w_head[CW-1:0];
  assign disp_rdata = mem_rdata;
  assign fifo_level = r_level;

  always_ff @(posedge pclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lw'(1);
        2'b01:   r_level <= r_level - c_lw'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  localparam int DW    = 15;
  localparam int CW    = 12;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          pclk      = 1'b0;
  logic          rstn      = 1'b0;
  logic          disp_en   = 1'b0;
  logic [DW-1:0] disp_addr = '0;
  logic          wr_valid  = 1'b0;
  logic [DW-1:0] wr_addr   = '0;
  logic [CW-1:0] wr_data   = '0;
  logic [CW-1:0] mem_rdata = '0;
  logic [CW-1:0] disp_rdata;
  logic          wr_ready;
  logic [DW-1:0] mem_addr;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic [LW-1:0] fifo_level;

  vram_arbiter #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .pclk       (pclk),
    .rstn       (rstn),
    .disp_en    (disp_en),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level)
  );

  always #10 pclk = ~pclk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  wr_t fifo_q[$];   // model of pending writes
  wr_t exp_q[$];    // scoreboard of writes still to be observed on the VRAM
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain queue updated by the acceptance/drain rules.
  always @(posedge pclk) begin : model
    bit do_push;
    bit do_pop;
    if (!rstn) begin
      fifo_q.delete();
      exp_q.delete();
    end else begin
      do_push = wr_valid && (fifo_q.size() != DEPTH);
      do_pop  = !disp_en && (fifo_q.size() > 0);
      if (do_pop) void'(fifo_q.pop_front());
      if (do_push) begin
        fifo_q.push_back('{a: wr_addr, d: wr_data});
        exp_q.push_back('{a: wr_addr, d: wr_data});
      end
    end
  end

  always @(negedge rstn) begin
    fifo_q.delete();
    exp_q.delete();
  end

  // Monitor: mid-cycle sampling of every output against the model.
  always @(negedge pclk) begin : monitor
    bit  exp_we;
    wr_t w;
    exp_we = rstn && !disp_en && (fifo_q.size() > 0);
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("wr_ready", 32'(wr_ready), 32'(rstn && (fifo_q.size() != DEPTH)));
    check("fifo_level", 32'(fifo_level), 32'(fifo_q.size()));
    check("disp_rdata", 32'(disp_rdata), 32'(mem_rdata));
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(1), 32'(0));
      end else begin
        w = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(w.a));
        check("write_data", 32'(mem_wdata), 32'(w.d));
      end
    end else begin
      check("read_addr", 32'(mem_addr), 32'(disp_addr));
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    // Reset held with a write offered during blanking
    rstn = 1'b0; wr_valid = 1'b1; disp_en = 1'b0; wr_addr = 15'h7; wr_data = 12'h777;
    repeat (3) step();
    rstn = 1'b1; wr_valid = 1'b0;
    step();

    // Single write in blanking
    wr_valid = 1'b1; wr_addr = 15'h0010; wr_data = 12'hF00;
    step();
    wr_valid = 1'b0;
    repeat (3) step();

    // Fill during active scan, then drain in blanking; write 5 held until taken
    disp_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_valid  = 1'b1;
      wr_addr   = DW'(i);
      wr_data   = CW'(i * 12'h111);
      disp_addr = DW'($urandom);
      step();
    end
    step();
    disp_en = 1'b0;
    repeat (2) step();
    wr_valid = 1'b0;
    repeat (6) step();

    // Simultaneous push and pop at level 2
    disp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = DW'(16'h100 + i); wr_data = CW'(12'hA0 + i);
      step();
    end
    disp_en = 1'b0; wr_addr = 15'h0200; wr_data = 12'hBEE;
    step();
    wr_valid = 1'b0;
    repeat (4) step();

    // Reset in the middle of a drain
    disp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = DW'(16'h300 + i); wr_data = CW'(12'hC00 + i);
      step();
    end
    wr_valid = 1'b0; disp_en = 1'b0;
    step();
    #3 rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (4) step();

    // Read passthrough
    disp_en = 1'b1; disp_addr = 15'h1234; mem_rdata = 12'hABC;
    step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) disp_en = ~disp_en;
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = DW'($urandom);
      wr_data   = CW'($urandom);
      disp_addr = DW'($urandom);
      mem_rdata = CW'($urandom);
      if ($urandom_range(0, 499) == 0) rstn = 1'b0;
      else rstn = 1'b1;
      step();
    end

    rstn = 1'b1; disp_en = 1'b0; wr_valid = 1'b0;
    repeat (DEPTH + 4) step();
    check("drained_all", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
